// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the memory macro.
// slave: the arbiter's view. master: the environment's view (requesters plus memory).
interface mem_bus_arbiter_if #(
  parameter int unsigned width    = 32,
  parameter int unsigned addrsize = 8,
  parameter int unsigned NREQ     = 2
);

  // Requester side
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0]          req_we;
  logic [NREQ*addrsize-1:0] req_addr;
  logic [NREQ*width-1:0]    req_wdata;
  logic [NREQ-1:0]          gnt;
  logic [NREQ-1:0]          rvalid;
  logic [width-1:0]         rdata;

  // Memory side
  logic                     mem_en;
  logic                     mem_we;
  logic [addrsize-1:0]      mem_addr;
  logic [width-1:0]         mem_wdata;
  logic [width-1:0]         mem_rdata;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between NREQ requesters.
// An owner keeps the bus for up to MAX_BURST consecutive grants while others wait, and
// indefinitely when alone. Reads return on rvalid/rdata one cycle after the grant.
module mem_bus_arbiter #(
  parameter int unsigned width     = 32,
  parameter int unsigned addrsize  = 8,
  parameter int unsigned NREQ      = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int unsigned IdxW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BeatW = 4;
  localparam logic [BeatW-1:0] MaxBeat = BeatW'(MAX_BURST);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic [NREQ-1:0]     rvalid_q, rvalid_d;
  logic [width-1:0]    rdata_q, rdata_d;

  logic                gnt_any;
  logic [IdxW-1:0]     gnt_idx;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     others;
  logic [NREQ-1:0]     rvalid;
  logic                read_back;

  // First set bit of mask scanning upward from base+1, wrapping mod NREQ; base itself last.
  function automatic logic [IdxW-1:0] next_from(input logic [NREQ-1:0] mask,
                                                input logic [IdxW-1:0] base);
    logic [IdxW-1:0] sel;
    int              j;
    sel = '0;
    // Walk farthest offset first so the nearest match overwrites it.
    for (int i = int'(NREQ); i >= 1; i--) begin
      j = (int'(base) + i) % int'(NREQ);
      if (mask[IdxW'(j)]) sel = IdxW'(j);
    end
    return sel;
  endfunction

  // Arbitration: pick this cycle's grant and the next owner/priority/burst state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    gnt_any = 1'b0;
    gnt_idx = owner_q;
    others  = bus.req & ~(NREQ'(1) << owner_q);

    if (!rst) begin
      case (state_q)
        StIdle: begin
          if (|bus.req) begin
            gnt_any = 1'b1;
            gnt_idx = next_from(bus.req, last_q);
            owner_d = gnt_idx;
            beat_d  = BeatW'(1);
            state_d = StOwn;
          end
        end
        StOwn: begin
          if (bus.req[owner_q] && ((beat_q < MaxBeat) || (others == '0))) begin
            gnt_any = 1'b1;
            gnt_idx = owner_q;
            if (beat_q < MaxBeat) beat_d = beat_q + BeatW'(1);
          end else if (|others) begin
            // Burst exhausted or owner released: hand over without an idle cycle.
            gnt_any = 1'b1;
            gnt_idx = next_from(others, owner_q);
            last_d  = owner_q;
            owner_d = gnt_idx;
            beat_d  = BeatW'(1);
          end else begin
            last_d  = owner_q;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Grant decode, memory-side mux and read-return bookkeeping.
  always_comb begin
    gnt           = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    bus.mem_en    = gnt_any;
    bus.mem_we    = gnt_any & bus.req_we[gnt_idx];
    bus.mem_addr  = gnt_any ? bus.req_addr[gnt_idx*addrsize +: addrsize] : '0;
    bus.mem_wdata = gnt_any ? bus.req_wdata[gnt_idx*width +: width] : '0;
    rvalid_d      = (gnt_any && !bus.req_we[gnt_idx]) ? gnt : '0;
    // A reset arriving while a read is in flight kills its return immediately.
    rvalid        = rvalid_q & {NREQ{~rst}};
    read_back     = |rvalid;
    rdata_d       = read_back ? bus.mem_rdata : rdata_q;
    bus.rdata     = read_back ? bus.mem_rdata : rdata_q;
  end

  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid;

  // State registers; priority restarts at requester 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      last_q   <= IdxW'(NREQ - 1);
      beat_q   <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with NREQ=2, MAX_BURST=4 and a behavioural memory.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  logic [31:0] mem [256];

  logic [1:0] seq_req [18];
  logic [1:0] seq_gnt [18];

  mem_bus_arbiter_if #(.width(32), .addrsize(8), .NREQ(2)) bus ();

  mem_bus_arbiter #(
    .width    (32),
    .addrsize (8),
    .NREQ     (2),
    .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model; preloads two read locations while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h11] <= 32'hCAFE0011;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input int i, input logic we, input logic [7:0] a,
                            input logic [31:0] d);
    bus.req_we[i]            = we;
    bus.req_addr[i*8 +: 8]   = a;
    bus.req_wdata[i*32 +: 32] = d;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    seq_req = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11,
                2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    seq_gnt = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01,
                2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};

    rst           = 1'b1;
    bus.req       = 2'b11;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset holds everything quiet even with requests pending
    @(negedge clk);
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    bus.req_we = 2'b11;
    #1;
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);

    // Single requester read
    @(negedge clk);
    rst     = 1'b0;
    bus.req = 2'b01;
    set_fields(0, 1'b0, 8'h10, 32'h0);
    set_fields(1, 1'b0, 8'h11, 32'h0);
    #1;
    chk("single_gnt", 32'(bus.gnt), 32'h1);
    chk("single_mem_en", 32'(bus.mem_en), 32'h1);
    chk("single_mem_addr", 32'(bus.mem_addr), 32'h10);
    chk("single_mem_we", 32'(bus.mem_we), 32'h0);
    @(negedge clk);
    chk("single_rvalid", 32'(bus.rvalid), 32'h1);
    chk("single_rdata", bus.rdata, 32'hDEADBEEF);
    bus.req = 2'b00;
    #1;
    chk("idle_gnt", 32'(bus.gnt), 32'h0);
    chk("idle_mem_en", 32'(bus.mem_en), 32'h0);
    chk("idle_mem_addr", 32'(bus.mem_addr), 32'h0);
    @(negedge clk);
    chk("idle_rvalid", 32'(bus.rvalid), 32'h0);

    // Burst limit, release handoff and beat restart, from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 18; k++) begin
      bus.req = seq_req[k];
      #1;
      chk($sformatf("seq%0d_gnt", k), 32'(bus.gnt), 32'(seq_gnt[k]));
      @(negedge clk);
      chk($sformatf("seq%0d_rvalid", k), 32'(bus.rvalid), 32'(seq_gnt[k]));
      if (seq_gnt[k] == 2'b01) chk($sformatf("seq%0d_rdata", k), bus.rdata, 32'hDEADBEEF);
      if (seq_gnt[k] == 2'b10) chk($sformatf("seq%0d_rdata", k), bus.rdata, 32'hCAFE0011);
    end

    // Write then read the same location
    bus.req = 2'b01;
    set_fields(0, 1'b1, 8'h20, 32'h12345678);
    #1;
    chk("wr_gnt", 32'(bus.gnt), 32'h1);
    chk("wr_mem_we", 32'(bus.mem_we), 32'h1);
    chk("wr_mem_addr", 32'(bus.mem_addr), 32'h20);
    chk("wr_mem_wdata", bus.mem_wdata, 32'h12345678);
    @(negedge clk);
    chk("wr_no_rvalid", 32'(bus.rvalid), 32'h0);
    set_fields(0, 1'b0, 8'h20, 32'h0);
    #1;
    chk("rd_gnt", 32'(bus.gnt), 32'h1);
    chk("rd_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rd_mem_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk);
    chk("rd_rvalid", 32'(bus.rvalid), 32'h1);
    chk("rd_rdata", bus.rdata, 32'h12345678);

    // Lone owner keeps the bus past MAX_BURST
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("lone%0d_gnt", k), 32'(bus.gnt), 32'h1);
      @(negedge clk);
      chk($sformatf("lone%0d_rvalid", k), 32'(bus.rvalid), 32'h1);
    end
    chk("lone_rdata", bus.rdata, 32'h12345678);
    bus.req = 2'b00;
    @(negedge clk);
    chk("lone_end_rvalid", 32'(bus.rvalid), 32'h0);

    // Reset while requester 1's read is in flight
    bus.req = 2'b10;
    #1;
    chk("mid_gnt1", 32'(bus.gnt), 32'h2);
    @(negedge clk);
    rst        = 1'b1;
    bus.req    = 2'b11;
    bus.req_we = 2'b01;
    #1;
    chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("mid_rst_mem_en", 32'(bus.mem_en), 32'h0);
    chk("mid_rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("mid_rst_rvalid", 32'(bus.rvalid), 32'h0);
    @(negedge clk);
    chk("post_rst_rvalid", 32'(bus.rvalid), 32'h0);
    rst        = 1'b0;
    bus.req_we = 2'b00;
    #1;
    chk("post_rst_gnt", 32'(bus.gnt), 32'h1);
    chk("post_rst_mem_addr", 32'(bus.mem_addr), 32'h20);
    @(negedge clk);
    chk("post_rst_rd_rvalid", 32'(bus.rvalid), 32'h1);
    chk("post_rst_rd_rdata", bus.rdata, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port synchronous data memory between NREQ requesters: processor core(s), program loader, debug port.
- Round-robin arbitration with bounded burst ownership.
- Each requester sees a simple req/gnt handshake; reads return one cycle after grant.
- Sits between the core's memory interface (we/address/dataout/datain) and the memory macro.

Parameters:
- width, 32, data bus width
- addrsize, 8, address bus width
- NREQ, 2, number of requesters (2..4); index 0 wins ties after reset
- MAX_BURST, 4, consecutive grants an owner may hold while others are waiting (1..15)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester access request, level
- req_we  in  NREQ  per-requester write enable (1 write, 0 read)
- req_addr  in  NREQ*addrsize  packed addresses, requester i at [i*addrsize +: addrsize]
- req_wdata  in  NREQ*width  packed write data, requester i at [i*width +: width]
- gnt  out  NREQ  one-hot grant, combinational from req and arbiter state
- rvalid  out  NREQ  one-hot read-data-valid, registered
- rdata  out  width  read data, broadcast; qualify with rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  addrsize  memory address
- mem_wdata  out  width  memory write data
- mem_rdata  in  width  memory read data, valid one cycle after a read strobe

Interface (already decided):
- One clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, owner=0, last=NREQ-1 (so requester 0 is first priority), beat=0, rvalid=0, rdata=0.
  - gnt, mem_en and mem_we are 0 while rst is high, regardless of req.
- States:
  - IDLE: no owner. If any req is set, grant the first requester found scanning (last+1) mod NREQ upward. Set owner to it, beat=1, go to OWN.
  - OWN: if req[owner]=1 and (beat<MAX_BURST or no other req set), re-grant owner; beat increments, saturating at MAX_BURST.
  - OWN: if req[owner]=1, beat==MAX_BURST and another req is set, grant the next requester found scanning from owner+1; last=owner, new owner, beat=1.
  - OWN: if req[owner]=0 and others are requesting, grant the next found scanning from owner+1 in the same cycle (no bubble); last=old owner.
  - OWN: if no req is set, gnt=0, last=owner, go to IDLE.
- Exactly zero or one gnt bit per cycle. A granted access completes in that cycle; there is no stall from memory.
- Memory side:
  - mem_en = |gnt.
  - mem_we, mem_addr and mem_wdata mux from the granted requester's fields; all are 0 when nothing is granted.
- Reads:
  - A granted read in cycle N gives rvalid[i]=1 and rdata=mem_rdata in cycle N+1, then rvalid drops.
  - Back-to-back reads give continuous rvalid.
  - A granted write produces no rvalid.
- A requester holding req without gnt must keep addr/we/wdata stable. The arbiter does not check this.
- rst mid-burst:
  - Any in-flight read's rvalid is suppressed (rvalid=0 next cycle).
  - Ownership is lost; priority restarts at requester 0.
- Requesters beyond NREQ do not exist; the scan is mod NREQ.

Test Plan:
- Single requester: rst 2 cycles, then req=01, we=0, addr=0x10 with mem[0x10]=0xDEADBEEF -> gnt=01 same cycle, mem_addr=0x10, mem_en=1; next cycle rvalid=01, rdata=0xDEADBEEF.
- Simultaneous first request: after reset req=11 -> gnt=01 first. Requester 0 holds req for 10 cycles with MAX_BURST=4 -> gnt sequence 01,01,01,01,10,01,01,01,01,10 (owner 1 released after one beat per scenario).
- Release handoff: owner 0 drops req while req[1]=1 -> gnt=10 in that same cycle, no idle cycle; beat resets to 1.
- Write then read: req0 writes 0x12345678 to 0x20, then reads 0x20 on the next grant -> mem_we=1 only on the write cycle; rvalid=01 with rdata=0x12345678 one cycle after the read grant; no rvalid after the write.
- Lone owner beyond burst: only req0 asserted for 8 cycles -> gnt=01 every cycle, no forced gap.
- Reset mid-burst: read granted to requester 1 at cycle N, rst=1 at cycle N+1 -> rvalid=0, gnt=0 during rst. After rst drops with req=11 -> gnt=01.
